// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI master
// Contents:
//   spi_state_e   transfer FSM states
//   SPI_MODE      {CPOL, CPHA} of the link (mode 0)
//   SPI_SCLK_IDLE sclk level while idle (CPOL)
//   cnt_w()       counter width helper, clog2 with a floor of 1 bit
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } spi_state_e;

  localparam logic [1:0] SPI_MODE      = 2'b00;
  localparam logic       SPI_SCLK_IDLE = SPI_MODE[1];

  // Width needed to hold values 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// rtl/spi_tick_gen.sv - half-period divider producing an end-of-phase tick
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          count while high; counter clears to 0 while low
//   tick        high on the last clk cycle of each CLK_DIV-cycle phase
module spi_tick_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int            CW   = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 master, one DATA_W-bit full-duplex word per start
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       transfer request, accepted while busy=0
//   tx_data     word to send, captured on the accept cycle
//   busy        high from the cycle after accept to the end of the gap
//   done        one-cycle pulse, rx_data valid from this cycle
//   rx_data     last received word
//   sclk        SPI clock, idles low
//   cs_n        chip select, active low
//   mosi        serial data out, MSB first
//   miso        serial data in, sampled on the last cycle of each high phase
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_master: CLK_DIV must be at least 2");
  end
  if (DATA_W < 1) begin : g_bad_data_w
    $error("spi_master: DATA_W must be at least 1");
  end

  localparam int            BW       = cnt_w(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  spi_state_e        state_q, state_d;
  logic              sclk_d, cs_n_d, mosi_d, busy_d, done_d;
  logic [DATA_W-1:0] rx_data_d;
  logic [DATA_W-1:0] tx_sh, tx_sh_d, tx_shl;
  logic [DATA_W-1:0] rx_sh, rx_sh_d;
  logic [BW-1:0]     bit_cnt, bit_cnt_d;
  logic              tick;

  // The divider runs for the whole transfer; each state lasts exactly one
  // divider period, so state changes happen only on tick.
  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q != IDLE),
    .tick (tick)
  );

  assign tx_shl = tx_sh << 1;

  always_comb begin
    state_d   = state_q;
    sclk_d    = sclk;
    cs_n_d    = cs_n;
    mosi_d    = mosi;
    busy_d    = busy;
    done_d    = 1'b0;
    rx_data_d = rx_data;
    tx_sh_d   = tx_sh;
    rx_sh_d   = rx_sh;
    bit_cnt_d = bit_cnt;

    unique case (state_q)
      IDLE: begin
        if (start && !busy) begin
          tx_sh_d   = tx_data;
          mosi_d    = tx_data[DATA_W-1];
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          state_d   = SETUP;
        end
      end
      SETUP, LOW: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (tick) begin
          // Sampling on the last high cycle: the slave only moves miso after
          // it sees the falling edge, so the bit is settled here.
          sclk_d  = 1'b0;
          rx_sh_d = (rx_sh << 1) | DATA_W'(miso);
          if (bit_cnt == LAST_BIT) begin
            state_d = HOLD;
          end else begin
            tx_sh_d   = tx_shl;
            mosi_d    = tx_shl[DATA_W-1];
            bit_cnt_d = bit_cnt + 1'b1;
            state_d   = LOW;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          cs_n_d    = 1'b1;
          done_d    = 1'b1;
          rx_data_d = rx_sh;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sclk    <= SPI_SCLK_IDLE;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
    end else begin
      state_q <= state_d;
      sclk    <= sclk_d;
      cs_n    <= cs_n_d;
      mosi    <= mosi_d;
      busy    <= busy_d;
      done    <= done_d;
      rx_data <= rx_data_d;
      tx_sh   <= tx_sh_d;
      rx_sh   <= rx_sh_d;
      bit_cnt <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - randomized self-checking bench for spi_master
module tb_spi_master;

  localparam int W   = 8;
  localparam int CD  = 2;
  localparam int CD1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, miso;
  logic [W-1:0] tx_data;
  logic         busy, done, sclk, cs_n, mosi;
  logic [W-1:0] rx_data;

  logic       start1, miso1;
  logic [0:0] tx1, rx1;
  logic       busy1, done1, sclk1, cs_n1, mosi1;

  int checks = 0;
  int errors = 0;

  spi_master #(.DATA_W(W), .CLK_DIV(CD)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data),
    .busy(busy), .done(done), .rx_data(rx_data),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  spi_master #(.DATA_W(1), .CLK_DIV(CD1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .tx_data(tx1),
    .busy(busy1), .done(done1), .rx_data(rx1),
    .sclk(sclk1), .cs_n(cs_n1), .mosi(mosi1), .miso(miso1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One transfer on the W=8 instance, checked cycle by cycle against the
  // timing formulas relative to the accept cycle T (k = cycles after T).
  // pre:  start is already high and the accept happens on the next edge.
  // hold: keep start high (with tx_alt on tx_data) for a back-to-back accept.
  // ign:  if >0, pulse start with 0x11 at that cycle (must be ignored).
  task automatic run_xfer(input logic [W-1:0] tx, input logic [W-1:0] sw,
                          input bit pre, input bit hold,
                          input logic [W-1:0] tx_alt, input int ign);
    int k_done = 1 + CD * (2 * W + 1);
    int k_end  = 1 + CD * (2 * W + 2);
    logic [W-1:0] seen = '0;
    int falls = 0;
    int dones = 0;
    logic prev_sclk = 1'b0;
    logic e_sclk;
    if (!pre) begin
      @(negedge clk);
      start   = 1'b1;
      tx_data = tx;
    end
    miso = sw[W-1];
    @(posedge clk);
    for (int k = 1; k <= k_end; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start   = hold;
        tx_data = hold ? tx_alt : W'($urandom);
      end
      if (ign > 0 && k == ign) begin
        start   = 1'b1;
        tx_data = 8'h11;
      end
      if (ign > 0 && k == ign + 1) start = 1'b0;
      e_sclk = (k < k_done) && (((k - 1) / CD) % 2 == 1);
      check($sformatf("sclk@%0d", k), sclk, e_sclk);
      check($sformatf("cs_n@%0d", k), cs_n, k >= k_done);
      check($sformatf("busy@%0d", k), busy, k < k_end);
      check($sformatf("done@%0d", k), done, k == k_done);
      if (k > CD && ((k - 1) % (2 * CD)) == CD && (k - 1 - CD) / (2 * CD) < W)
        seen[W - 1 - (k - 1 - CD) / (2 * CD)] = mosi;
      if (done) dones++;
      if (k == k_done) check("rx_data", rx_data, sw);
      // Model slave: present the next bit after each observed falling edge.
      if (prev_sclk && !sclk) falls++;
      prev_sclk = sclk;
      if (falls < W) miso = sw[W - 1 - falls];
    end
    check("mosi_word", seen, tx);
    check("done_count", dones, 1);
  endtask

  initial begin
    int rises;
    int done_k;
    logic prev;
    rst_n = 1'b0; start = 1'b0; tx_data = '0; miso = 1'b0;
    start1 = 1'b0; tx1 = 1'b0; miso1 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sclk", sclk, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rx", rx_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer(8'hA5, 8'h3C, 1'b0, 1'b0, 8'h00, 0);
    run_xfer(8'hFF, 8'h5A, 1'b0, 1'b1, 8'h00, 0);
    run_xfer(8'h00, 8'hC3, 1'b1, 1'b0, 8'h00, 0);
    run_xfer(8'hA5, 8'h81, 1'b0, 1'b0, 8'h00, 10);

    // Asynchronous reset in the middle of cycle 12 of a transfer.
    @(negedge clk);
    start = 1'b1; tx_data = 8'hA5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_sclk", sclk, 0);
    check("mid_rst_cs_n", cs_n, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rx", rx_data, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_done", done, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
    end
    run_xfer(8'h96, 8'h69, 1'b0, 1'b0, 8'h00, 0);

    for (int n = 0; n < 256; n++)
      run_xfer(W'($urandom), W'($urandom), 1'b0, 1'b0, 8'h00, 0);

    // DATA_W=1 instance: a single sclk pulse, done at T+1+3*CLK_DIV.
    @(negedge clk);
    start1 = 1'b1; tx1 = 1'b1;
    @(posedge clk);
    rises = 0; done_k = -1; prev = 1'b0;
    for (int k = 1; k <= 1 + 4 * CD1; k++) begin
      @(negedge clk);
      if (k == 1) start1 = 1'b0;
      if (sclk1 && !prev) begin
        rises++;
        check("w1_mosi", mosi1, 1);
      end
      prev = sclk1;
      if (done1) begin
        done_k = k;
        check("w1_rx", rx1, 1);
      end
    end
    check("w1_rises", rises, 1);
    check("w1_done_at", done_k, 1 + 3 * CD1);
    check("w1_busy_end", busy1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
